// File: rtl/ghash_ctrl.sv
// Sequencing FSM for the GHASH datapath: load H, clear, fold AAD/CT/length blocks, pulse done.
// Optional abort input and flush state are compiled in when GHASH_CTRL_ABORT_EN is defined.
module ghash_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] aad_blocks,
    input  logic [CNT_W-1:0] ct_blocks,
    input  logic             in_valid,
`ifdef GHASH_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             in_ready,
    output logic             h_reg_en,
    output logic [1:0]       mux_sel,
    output logic             ac_reg_en,
    output logic             ac_clr,
    output logic             s_clr,
    output logic             s_reg_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_H,
        CLR,
        AAD_ACC,
        AAD_MUL,
        CT_ACC,
        CT_MUL,
        LEN_ACC,
        LEN_MUL,
        DONE
`ifdef GHASH_CTRL_ABORT_EN
        , FLUSH
`endif
    } state_t;

    localparam logic [1:0] SEL_AAD = 2'b00;
    localparam logic [1:0] SEL_CT  = 2'b01;
    localparam logic [1:0] SEL_LEN = 2'b10;

    // Per-state output image; acc marks the handshaking accumulate states.
    typedef struct packed {
        logic       h_reg_en;
        logic [1:0] mux_sel;
        logic       acc;
        logic       len;
        logic       ac_clr;
        logic       s_clr;
        logic       s_reg_en;
        logic       busy;
        logic       done;
    } out_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] a_cnt, a_nx;
    logic [CNT_W-1:0] c_cnt, c_nx;
    out_t             outs;

    function automatic out_t decode(input state_t s);
        out_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            LOAD_H:  o.h_reg_en = 1'b1;
            CLR: begin
                o.ac_clr = 1'b1;
                o.s_clr  = 1'b1;
            end
            AAD_ACC: begin
                o.mux_sel = SEL_AAD;
                o.acc     = 1'b1;
            end
            AAD_MUL: begin
                o.mux_sel  = SEL_AAD;
                o.s_reg_en = 1'b1;
            end
            CT_ACC: begin
                o.mux_sel = SEL_CT;
                o.acc     = 1'b1;
            end
            CT_MUL: begin
                o.mux_sel  = SEL_CT;
                o.s_reg_en = 1'b1;
            end
            LEN_ACC: begin
                o.mux_sel = SEL_LEN;
                o.len     = 1'b1;
            end
            LEN_MUL: begin
                o.mux_sel  = SEL_LEN;
                o.s_reg_en = 1'b1;
            end
            DONE:    o.done = 1'b1;
`ifdef GHASH_CTRL_ABORT_EN
            FLUSH: begin
                o.ac_clr = 1'b1;
                o.s_clr  = 1'b1;
            end
`endif
            default: ;
        endcase
        return o;
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        a_nx     = a_cnt;
        c_nx     = c_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD_H;
                    a_nx     = aad_blocks;
                    c_nx     = ct_blocks;
                end
            end
            LOAD_H:  state_nx = CLR;
            CLR: begin
                if (a_cnt != '0)      state_nx = AAD_ACC;
                else if (c_cnt != '0) state_nx = CT_ACC;
                else                  state_nx = LEN_ACC;
            end
            AAD_ACC: begin
                if (in_valid) begin
                    a_nx     = a_cnt - 1'b1;
                    state_nx = AAD_MUL;
                end
            end
            AAD_MUL: begin
                if (a_cnt != '0)      state_nx = AAD_ACC;
                else if (c_cnt != '0) state_nx = CT_ACC;
                else                  state_nx = LEN_ACC;
            end
            CT_ACC: begin
                if (in_valid) begin
                    c_nx     = c_cnt - 1'b1;
                    state_nx = CT_MUL;
                end
            end
            CT_MUL:  state_nx = (c_cnt != '0) ? CT_ACC : LEN_ACC;
            LEN_ACC: state_nx = LEN_MUL;
            LEN_MUL: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
`ifdef GHASH_CTRL_ABORT_EN
        if (abort && (state != IDLE)) state_nx = FLUSH;
`endif
    end

    // Outputs are registered from the next-state decode, so they line up with state.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_cnt <= '0;
            c_cnt <= '0;
            outs  <= '0;
        end else begin
            state <= state_nx;
            a_cnt <= a_nx;
            c_cnt <= c_nx;
            outs  <= decode(state_nx);
        end
    end

    assign in_ready  = outs.acc;
    assign ac_reg_en = outs.len | (outs.acc & in_valid);
    assign h_reg_en  = outs.h_reg_en;
    assign mux_sel   = outs.mux_sel;
    assign ac_clr    = outs.ac_clr;
    assign s_clr     = outs.s_clr;
    assign s_reg_en  = outs.s_reg_en;
    assign busy      = outs.busy;
    assign done      = outs.done;

endmodule
